// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes and FSM state type for the data memory controller
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between the MEM stage (master) and the data memory (slave)
//   req_valid/req_ready/req_write/req_func3/req_addr/req_wdata: request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_fault: response channel
interface data_mem_ctrl_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: fault/alignment check, store byte enables and load extension
//   i_write/i_func3/i_addr: access type and low address bits; i_bytes: bytes {a+3,a+2,a+1,a}
//   o_fault: illegal or misaligned; o_be: store byte enables; o_rdata: extended load data (0 for stores/faults)
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_bytes,
  output logic        o_fault,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);
  logic w_h, w_w, w_legal, w_sx;
  // size decode ignores bit 2 so LH/LHU share the halfword path; illegal codes are caught by w_legal
  assign w_h = i_func3[1:0] == 2'b01;
  assign w_w = i_func3[1:0] == 2'b10;
  assign w_legal = i_write ? (i_func3 == F3_B || i_func3 == F3_H || i_func3 == F3_W)
                           : (i_func3 == F3_B || i_func3 == F3_H || i_func3 == F3_W ||
                              i_func3 == F3_BU || i_func3 == F3_HU);
  assign o_fault = !w_legal || (w_h && i_addr[0]) || (w_w && i_addr != 2'b00);
  assign w_sx = !i_func3[2];
  assign o_be = (o_fault || !i_write) ? 4'h0 : w_w ? 4'hf : w_h ? 4'h3 : 4'h1;
  assign o_rdata = (o_fault || i_write) ? 32'h0 :
                   w_w ? i_bytes :
                   w_h ? {{16{w_sx & i_bytes[15]}}, i_bytes[15:0]} :
                         {{24{w_sx & i_bytes[7]}}, i_bytes[7:0]};
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed little-endian data memory with valid/ready handshake and wait states
//   clk: clock; rst: asynchronous active-low reset; bus: slave side of data_mem_ctrl_if
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_write, r_fault;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [7:0]        r_mem [2**ADDR_W];
  logic              w_idle, w_acc, w_commit, w_write, w_fault;
  logic [2:0]        w_func3;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_bytes, w_rdata;
  logic [3:0]        w_be;
  assign w_idle        = r_state == IDLE;
  assign bus.req_ready = w_idle;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_fault = r_fault;
  assign w_acc = bus.req_valid && w_idle;
  // with zero wait states the commit edge is the acceptance edge, so the live request is used
  assign w_write = w_idle ? bus.req_write : r_write;
  assign w_func3 = w_idle ? bus.req_func3 : r_func3;
  assign w_addr  = w_idle ? bus.req_addr  : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
  // gated by rst so an edge seen while reset is held never writes memory
  assign w_commit = rst && (w_idle ? (w_acc && WS == 4'd0) : (r_state == WAIT && r_cnt == WS));
  assign w_bytes = {r_mem[w_addr + ADDR_W'(3)], r_mem[w_addr + ADDR_W'(2)],
                    r_mem[w_addr + ADDR_W'(1)], r_mem[w_addr]};
  dmem_lane_align u_align (
    .i_write (w_write),
    .i_func3 (w_func3),
    .i_addr  (w_addr[1:0]),
    .i_bytes (w_bytes),
    .o_fault (w_fault),
    .o_be    (w_be),
    .o_rdata (w_rdata)
  );
  always_comb begin
    w_next = r_state;
    w_next = (w_idle && w_acc) ? ((WS == 4'd0) ? RESP : WAIT) :
             (r_state == WAIT && r_cnt == WS) ? RESP :
             (r_state == RESP && bus.rsp_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_func3 <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_write <= bus.req_write;
        r_func3 <= bus.req_func3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= 4'd1;
      end else if (r_state == WAIT) r_cnt <= r_cnt + 4'd1;
      if (w_commit) begin
        r_rdata <= w_rdata;
        r_fault <= w_fault;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_commit)
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_addr + ADDR_W'(k)] <= w_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl with WAIT_STATES=1 (u0) and 0 (u1)
module tb_data_mem_ctrl;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  data_mem_ctrl_if #(.ADDR_W(10)) b0();
  data_mem_ctrl_if #(.ADDR_W(10)) b1();
  data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  data_mem_ctrl #(.ADDR_W(10), .WAIT_STATES(0)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit d, input logic v, input logic wr, input logic [2:0] f3,
                       input logic [9:0] a, input logic [31:0] wd);
    if (d) begin
      b1.req_valid = v; b1.req_write = wr; b1.req_func3 = f3; b1.req_addr = a; b1.req_wdata = wd;
    end else begin
      b0.req_valid = v; b0.req_write = wr; b0.req_func3 = f3; b0.req_addr = a; b0.req_wdata = wd;
    end
  endtask
  task automatic obs(input bit d, output logic rv, output logic rr, output logic flt, output logic [31:0] rd);
    rv  = d ? b1.rsp_valid : b0.rsp_valid;
    rr  = d ? b1.req_ready : b0.req_ready;
    flt = d ? b1.rsp_fault : b0.rsp_fault;
    rd  = d ? b1.rsp_rdata : b0.rsp_rdata;
  endtask
  task automatic xact(input bit d, input logic wr, input logic [2:0] f3, input logic [9:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic flt, output int lat);
    logic rv, rr;
    @(negedge clk);
    drive(d, 1'b1, wr, f3, a, wd);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 3'd0, 10'd0, 32'd0);
    lat = 1;
    obs(d, rv, rr, flt, rd);
    while (!rv && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      obs(d, rv, rr, flt, rd);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input bit d, input string tag, input logic [2:0] f3, input logic [9:0] a,
                    input logic [31:0] exp, input logic expflt);
    logic [31:0] rd;
    logic flt;
    int lat;
    xact(d, 1'b0, f3, a, 32'd0, rd, flt, lat);
    chk(tag, rd, exp);
    chk({tag, "_flt"}, 32'(flt), 32'(expflt));
    chk({tag, "_lat"}, 32'(lat), d ? 32'd1 : 32'd2);
  endtask
  task automatic st(input bit d, input string tag, input logic [2:0] f3, input logic [9:0] a,
                    input logic [31:0] wd, input logic expflt);
    logic [31:0] rd;
    logic flt;
    int lat;
    xact(d, 1'b1, f3, a, wd, rd, flt, lat);
    chk(tag, rd, 32'd0);
    chk({tag, "_flt"}, 32'(flt), 32'(expflt));
  endtask
  initial begin
    logic rv, rr, flt;
    logic [31:0] rd;
    int n;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 10'd0, 32'd0);
    b0.rsp_ready = 1'b1;
    b1.rsp_ready = 1'b1;
    #12;
    obs(1'b0, rv, rr, flt, rd);
    chk("rst_valid", 32'(rv), 32'd0);
    chk("rst_rdata", rd, 32'd0);
    chk("rst_fault", 32'(flt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(b0.req_ready), 32'd1);
    st(1'b0, "sw_10", F3_W, 10'h010, 32'hDEADBEEF, 1'b0);
    ld(1'b0, "lw_10", F3_W, 10'h010, 32'hDEADBEEF, 1'b0);
    ld(1'b0, "lb_13", F3_B, 10'h013, 32'hFFFFFFDE, 1'b0);
    ld(1'b0, "lbu_13", F3_BU, 10'h013, 32'h000000DE, 1'b0);
    ld(1'b0, "lh_12", F3_H, 10'h012, 32'hFFFFDEAD, 1'b0);
    ld(1'b0, "lhu_10", F3_HU, 10'h010, 32'h0000BEEF, 1'b0);
    st(1'b0, "sb_11", F3_B, 10'h011, 32'hFFFFFF12, 1'b0);
    ld(1'b0, "lw_sb", F3_W, 10'h010, 32'hDEAD12EF, 1'b0);
    ld(1'b0, "lw_11", F3_W, 10'h011, 32'h0, 1'b1);
    st(1'b0, "sh_13", F3_H, 10'h013, 32'h00005555, 1'b1);
    st(1'b0, "s_f3_4", F3_BU, 10'h010, 32'h00000077, 1'b1);
    ld(1'b0, "lw_keep", F3_W, 10'h010, 32'hDEAD12EF, 1'b0);
    ld(1'b0, "l_f3_3", 3'b011, 10'h010, 32'h0, 1'b1);
    ld(1'b0, "l_f3_6", 3'b110, 10'h010, 32'h0, 1'b1);
    // response backpressure with a competing request held on the bus
    b0.rsp_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, F3_W, 10'h010, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, F3_BU, 10'h011, 32'd0);
    n = 0;
    while (!b0.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_lat", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(b0.rsp_valid), 32'd1);
      chk("hold_rdata", b0.rsp_rdata, 32'hDEAD12EF);
      chk("hold_ready", 32'(b0.req_ready), 32'd0);
    end
    @(negedge clk);
    b0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", 32'(b0.rsp_valid), 32'd0);
    chk("hs_ready", 32'(b0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("next_acc", 32'(b0.req_ready), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 32'd0);
    n = 0;
    while (!b0.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("next_rdata", b0.rsp_rdata, 32'h00000012);
    @(posedge clk);
    #1;
    // reset in the middle of the wait state discards the store
    st(1'b0, "sw_20_zero", F3_W, 10'h020, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, F3_W, 10'h020, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 10'd0, 32'd0);
    chk("mid_wait_ready", 32'(b0.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(b0.rsp_valid), 32'd0);
    chk("abort_ready", 32'(b0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_valid2", 32'(b0.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ld(1'b0, "lw_20", F3_W, 10'h020, 32'h0, 1'b0);
    st(1'b1, "ws0_sw", F3_W, 10'h040, 32'h11223344, 1'b0);
    ld(1'b1, "ws0_lw", F3_W, 10'h040, 32'h11223344, 1'b0);
    ld(1'b1, "ws0_lh", F3_H, 10'h042, 32'h00001122, 1'b0);
    ld(1'b1, "ws0_lb", F3_B, 10'h040, 32'h00000044, 1'b0);
    ld(1'b1, "ws0_lhmis", F3_H, 10'h041, 32'h0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed, little-endian data memory with a valid/ready request/response handshake and a configurable number of wait states.
- Supports RV32I loads LB/LH/LW/LBU/LHU and stores SB/SH/SW.
- Reports misaligned accesses and illegal func3 codes as faults instead of performing the access.
- Sits between the core's MEM stage and the data store; it replaces the single-cycle combinational-read data memory.

Parameters:
- ADDR_W, 10, byte-address width; memory depth is 2**ADDR_W bytes.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_func3  input  3  RV32I funct3 of the load/store.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low bytes are used for SB/SH.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and faults.
- rsp_fault  output  1  access was misaligned or illegal; no memory effect.

Behaviour:
- Reset (rst=0, asynchronous):
  - state <= IDLE, wait counter <= 0.
  - rsp_valid=0, rsp_rdata=0, rsp_fault=0; req_ready=1 once rst is released.
  - Memory array is not cleared.
  - Reset during WAIT or RESP aborts the transaction. A store whose commit edge has not yet occurred is discarded.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE).
  - IDLE: on req_valid & req_ready, latch write/func3/addr/wdata, then go to WAIT (WAIT_STATES>0) or straight to RESP (WAIT_STATES=0).
  - WAIT: counter counts 1..WAIT_STATES. The edge that ends WAIT is the commit edge; the FSM enters RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_fault are held stable until rsp_valid & rsp_ready, then the FSM returns to IDLE.
- Commit edge (end of WAIT, or the acceptance edge when WAIT_STATES=0): the store is written or the load data is captured into rsp_rdata.
- Latency: request accepted at edge T gives rsp_valid high from T+1+WAIT_STATES.
- Throughput: with rsp_ready tied high, one access every 2+WAIT_STATES cycles. No new request is accepted while in RESP, even during the handshake cycle.
- Fault rules (checked on the latched request):
  - Halfword access with addr[0]!=0 faults.
  - Word access with addr[1:0]!=0 faults.
  - Load func3 of 011, 110 or 111 faults.
  - Store func3 other than 000, 001 or 010 faults.
  - On fault: no byte is written, rsp_rdata=0, rsp_fault=1.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW assembles bytes {a+3, a+2, a+1, a}.
- Stores write only the addressed bytes (1, 2 or 4). All other bytes are unchanged.
- Address arithmetic is ADDR_W bits wide. Because of the alignment rules, a legal multi-byte access never wraps past the top of memory.
- Changes on req_* while not accepted have no effect. Signals are sampled only at acceptance.

Decomposition:
- Shared package dmem_pkg holds:
  - func3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state typedef {IDLE, WAIT, RESP}.
- One natural sub-module: dmem_lane_align. It is combinational and handles load byte-select plus extension, and the fault/alignment check.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_fault=0; rsp_valid rises exactly 1+WAIT_STATES cycles after acceptance.
- After the above: LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x010 -> 0x0000BEEF.
- SB 0x12 @0x011, then LW @0x010 -> 0xDEAD12EF (only one byte changed).
- LW @0x011 and SH @0x013 -> rsp_fault=1, rsp_rdata=0; LW @0x010 still returns the prior value. Load func3=011 -> fault.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, the new request is not accepted until the cycle after the handshake.
- Pull rst low mid-WAIT on SW 0xCAFEF00D @0x020 (prior value 0) -> rsp_valid=0 immediately. After release, LW @0x020 -> 0x00000000. Repeat with WAIT_STATES=0 -> latency is 1 cycle.
